slt_sltu_seq: RTL and testbench

- Multi-cycle, parametrised set-less-than unit for the RISC-V datapath.
- Computes SLT (signed) or SLTU (unsigned) of two WIDTH-bit operands.
- Uses a registered borrow chain that processes CHUNK bits per cycle, LSB chunk first.
- Trades latency for area; fronted by a valid/ready handshake so the execute stage can stall on it.

---
 rtl/slt_sltu_seq_if.sv | 42 ++++
 rtl/slt_sltu_seq.sv | 158 +++++++++++++++
 tb/tb_slt_sltu_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/slt_sltu_seq_if.sv
// ============================================================================
// Module   : slt_sltu_seq_if
// Brief    : Request/response bundle for the sequential set-less-than unit.
//            SLT_SEQ_EQ_FLAG_EN adds the O_Eq response signal.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface slt_sltu_seq_if #(
  parameter int WIDTH = 32
);
  logic             I_Valid;
  logic             O_Ready;
  logic [WIDTH-1:0] I_OP_A;
  logic [WIDTH-1:0] I_OP_B;
  logic             I_U;
  logic             I_Flush;
  logic             O_Valid;
  logic             I_Ready;
  logic             O_Result;
`ifdef SLT_SEQ_EQ_FLAG_EN
  logic             O_Eq;
`endif

  modport slave (
    input  I_Valid, I_OP_A, I_OP_B, I_U, I_Flush, I_Ready,
    output O_Ready, O_Valid, O_Result
`ifdef SLT_SEQ_EQ_FLAG_EN
    , output O_Eq
`endif
  );

  modport master (
    output I_Valid, I_OP_A, I_OP_B, I_U, I_Flush, I_Ready,
    input  O_Ready, O_Valid, O_Result
`ifdef SLT_SEQ_EQ_FLAG_EN
    , input O_Eq
`endif
  );
endinterface

`default_nettype wire

// File: rtl/slt_sltu_seq.sv
// ============================================================================
// Module   : slt_sltu_seq
// Brief    : Multi-cycle SLT/SLTU, CHUNK bits per cycle via a registered
//            borrow chain. SLT_SEQ_EQ_FLAG_EN adds the O_Eq equality flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module slt_sltu_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic          I_CLK,
  input  logic          I_RST_N,
  slt_sltu_seq_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_err
      $error("slt_sltu_seq: WIDTH must be >= 2 and divisible by CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               u_q, u_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               result_q, result_d;
  logic [CHUNK:0]     w_diff;
  logic               w_last;
`ifdef SLT_SEQ_EQ_FLAG_EN
  logic               zacc_q, zacc_d;
  logic               eq_q, eq_d;
  logic               w_zero;
`endif

  // Top bit of the (CHUNK+1)-bit difference is the borrow out of this chunk.
  assign w_diff = {1'b0, a_q[CHUNK-1:0]} - {1'b0, b_q[CHUNK-1:0]}
                - {{CHUNK{1'b0}}, borrow_q};
  assign w_last = (cnt_q == CNT_W'(NCHUNK - 1));
`ifdef SLT_SEQ_EQ_FLAG_EN
  assign w_zero = (w_diff[CHUNK-1:0] == '0);
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    u_d      = u_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    result_d = result_q;
`ifdef SLT_SEQ_EQ_FLAG_EN
    zacc_d   = zacc_q;
    eq_d     = eq_q;
`endif
    if (bus.I_Flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.I_Valid) begin
            a_d      = bus.I_OP_A;
            b_d      = bus.I_OP_B;
            u_d      = bus.I_U;
            sa_d     = bus.I_OP_A[WIDTH-1];
            sb_d     = bus.I_OP_B[WIDTH-1];
            borrow_d = 1'b0;
            cnt_d    = '0;
`ifdef SLT_SEQ_EQ_FLAG_EN
            zacc_d   = 1'b1;
`endif
            state_d  = S_BUSY;
          end
        end
        S_BUSY: begin
          borrow_d = w_diff[CHUNK];
          a_d      = a_q >> CHUNK;
          b_d      = b_q >> CHUNK;
          cnt_d    = cnt_q + CNT_W'(1);
`ifdef SLT_SEQ_EQ_FLAG_EN
          zacc_d   = zacc_q & w_zero;
`endif
          if (w_last) begin
            // Differing signs in signed mode: the negative operand is smaller.
            result_d = (u_q || (sa_q == sb_q)) ? w_diff[CHUNK] : sa_q;
`ifdef SLT_SEQ_EQ_FLAG_EN
            eq_d     = zacc_q & w_zero;
`endif
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          if (bus.I_Ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      u_q      <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      result_q <= 1'b0;
`ifdef SLT_SEQ_EQ_FLAG_EN
      zacc_q   <= 1'b0;
      eq_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      u_q      <= u_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
`ifdef SLT_SEQ_EQ_FLAG_EN
      zacc_q   <= zacc_d;
      eq_q     <= eq_d;
`endif
    end
  end

  assign bus.O_Ready  = (state_q == S_IDLE);
  assign bus.O_Valid  = (state_q == S_DONE);
  assign bus.O_Result = result_q;
`ifdef SLT_SEQ_EQ_FLAG_EN
  assign bus.O_Eq     = eq_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_slt_sltu_seq.sv
// ============================================================================
// Module   : tb_slt_sltu_seq
// Brief    : Self-checking bench; three instances (32/4, 16/16, 8/1) share
//            stimulus and are compared against an arithmetic reference.
//            Honours SLT_SEQ_EQ_FLAG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slt_sltu_seq;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  slt_sltu_seq_if #(.WIDTH(32)) bus0 ();
  slt_sltu_seq_if #(.WIDTH(16)) bus1 ();
  slt_sltu_seq_if #(.WIDTH(8))  bus2 ();

  slt_sltu_seq #(.WIDTH(32), .CHUNK(4))  u_dut0 (.I_CLK(clk), .I_RST_N(rst_n), .bus(bus0.slave));
  slt_sltu_seq #(.WIDTH(16), .CHUNK(16)) u_dut1 (.I_CLK(clk), .I_RST_N(rst_n), .bus(bus1.slave));
  slt_sltu_seq #(.WIDTH(8),  .CHUNK(1))  u_dut2 (.I_CLK(clk), .I_RST_N(rst_n), .bus(bus2.slave));

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: interpret the low w bits as signed or unsigned and compare.
  function automatic bit golden(input logic [31:0] a, input logic [31:0] b, input bit u, input int w);
    longint one = 1;
    longint m   = (one << w) - 1;
    longint ma  = {32'b0, a} & m;
    longint mb  = {32'b0, b} & m;
    if (!u) begin
      if (ma >= (one << (w - 1))) ma = ma - (one << w);
      if (mb >= (one << (w - 1))) mb = mb - (one << w);
    end
    return ma < mb;
  endfunction

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic u);
    bus0.I_Valid = v; bus0.I_OP_A = a;       bus0.I_OP_B = b;       bus0.I_U = u;
    bus1.I_Valid = v; bus1.I_OP_A = a[15:0]; bus1.I_OP_B = b[15:0]; bus1.I_U = u;
    bus2.I_Valid = v; bus2.I_OP_A = a[7:0];  bus2.I_OP_B = b[7:0];  bus2.I_U = u;
  endtask

  task automatic set_ready(input logic r);
    bus0.I_Ready = r; bus1.I_Ready = r; bus2.I_Ready = r;
  endtask

  // Issue one request to all instances, check latency/result, optionally
  // stall for 'hold' cycles, and optionally consume the result.
  task automatic run_all(input logic [31:0] a, input logic [31:0] b, input bit u,
                         input int hold, input bit consume);
    int lat[3] = '{-1, -1, -1};
    bit e0 = golden(a, b, u, 32);
    bit e1 = golden(a, b, u, 16);
    bit e2 = golden(a, b, u, 8);
    chk("ready_before", {61'b0, bus0.O_Ready, bus1.O_Ready, bus2.O_Ready}, 64'h7);
    drive(1'b1, a, b, u);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, $urandom, $urandom, 1'($urandom_range(1)));
    for (int c = 0; c < 40; c++) begin
      if (lat[0] < 0 && bus0.O_Valid) lat[0] = c;
      if (lat[1] < 0 && bus1.O_Valid) lat[1] = c;
      if (lat[2] < 0 && bus2.O_Valid) lat[2] = c;
      if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
      @(negedge clk);
    end
    chk("latency32", 64'(lat[0]), 64'd8);
    chk("latency16", 64'(lat[1]), 64'd1);
    chk("latency8",  64'(lat[2]), 64'd8);
    chk("result32", {63'b0, bus0.O_Result}, {63'b0, e0});
    chk("result16", {63'b0, bus1.O_Result}, {63'b0, e1});
    chk("result8",  {63'b0, bus2.O_Result}, {63'b0, e2});
`ifdef SLT_SEQ_EQ_FLAG_EN
    chk("eq32", {63'b0, bus0.O_Eq}, {63'b0, a == b});
    chk("eq16", {63'b0, bus1.O_Eq}, {63'b0, a[15:0] == b[15:0]});
    chk("eq8",  {63'b0, bus2.O_Eq}, {63'b0, a[7:0] == b[7:0]});
`endif
    for (int h = 0; h < hold; h++) begin
      drive(1'(h % 2 == 0), $urandom, $urandom, 1'($urandom_range(1)));
      @(negedge clk);
      chk("hold_valid", {61'b0, bus0.O_Valid, bus1.O_Valid, bus2.O_Valid}, 64'h7);
      chk("hold_ready", {61'b0, bus0.O_Ready, bus1.O_Ready, bus2.O_Ready}, 64'h0);
      chk("hold_result", {61'b0, bus0.O_Result, bus1.O_Result, bus2.O_Result}, {61'b0, e0, e1, e2});
    end
    drive(1'b0, $urandom, $urandom, 1'b0);
    if (consume) begin
      set_ready(1'b1);
      @(negedge clk);
      set_ready(1'b0);
      chk("consume", {58'b0, bus0.O_Valid, bus1.O_Valid, bus2.O_Valid,
                      bus0.O_Ready, bus1.O_Ready, bus2.O_Ready}, 64'h7);
    end
  endtask

  initial begin
    bit seen_valid;
    logic [31:0] ra, rb;
    drive(1'b0, '0, '0, 1'b0);
    set_ready(1'b0);
    bus0.I_Flush = 1'b0; bus1.I_Flush = 1'b0; bus2.I_Flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready",  {63'b0, bus0.O_Ready},  64'h1);
    chk("reset_valid",  {63'b0, bus0.O_Valid},  64'h0);
    chk("reset_result", {63'b0, bus0.O_Result}, 64'h0);
`ifdef SLT_SEQ_EQ_FLAG_EN
    chk("reset_eq", {63'b0, bus0.O_Eq}, 64'h0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    run_all(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b1);
    run_all(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 0, 1'b1);
    run_all(32'h0000_0010, 32'h0000_000F, 1'b0, 0, 1'b1);
    run_all(32'h0000_000F, 32'h0000_0010, 1'b0, 0, 1'b1);
    run_all(32'h8000_0000, 32'h8000_0000, 1'b0, 0, 1'b1);
    run_all(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 1'b1);
    run_all(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 5, 1'b1);

    // Flush on the third BUSY cycle of instance 0.
    bus0.I_Valid = 1'b1; bus0.I_OP_A = 32'hFFFF_FFFF; bus0.I_OP_B = 32'h1; bus0.I_U = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus0.I_Valid = 1'b0;
    repeat (2) @(negedge clk);
    bus0.I_Flush = 1'b1;
    @(negedge clk);
    bus0.I_Flush = 1'b0;
    chk("flush_idle", {62'b0, bus0.O_Ready, bus0.O_Valid}, 64'h2);
    seen_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen_valid = seen_valid | bus0.O_Valid;
    end
    chk("flush_no_valid", {63'b0, seen_valid}, 64'h0);
    run_all(32'h1234_5678, 32'h1234_5679, 1'b1, 0, 1'b1);

    // Async reset while results are pending.
    run_all(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid",  {61'b0, bus0.O_Valid, bus1.O_Valid, bus2.O_Valid}, 64'h0);
    chk("async_rst_result", {63'b0, bus0.O_Result}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      case (i % 4)
        0:       rb = ra;
        1:       rb = ra ^ (32'h1 << $urandom_range(31));
        default: rb = $urandom;
      endcase
      run_all(ra, rb, 1'($urandom_range(1)), (i % 7 == 0) ? 2 : 0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

`default_nettype wire
